// File: rtl/ternary_bus_if.sv
// Host-side bundle of the ternary accelerator bus driver: op/payload handshakes,
// DUT pin image and packed result return. Suffixes are from the driver's point of view.
interface ternary_bus_if #(
    parameter int OUT_LEN   = 8,
    parameter int BIT_WIDTH = 8
);
    logic                         op_valid_i;
    logic                         op_ready_o;
    logic                         op_is_mult_i;
    logic [15:0]                  in_data_i;
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic [15:0]                  bus_out_o;
    logic [BIT_WIDTH-1:0]         bus_in_i;
    logic                         dut_rst_n_o;
    logic [OUT_LEN*BIT_WIDTH-1:0] res_data_o;
    logic                         res_valid_o;
    logic                         res_ready_i;

    modport master (
        input  op_valid_i,
        input  op_is_mult_i,
        input  in_data_i,
        input  in_valid_i,
        input  bus_in_i,
        input  res_ready_i,
        output op_ready_o,
        output in_ready_o,
        output bus_out_o,
        output dut_rst_n_o,
        output res_data_o,
        output res_valid_o
    );

    modport slave (
        output op_valid_i,
        output op_is_mult_i,
        output in_data_i,
        output in_valid_i,
        output bus_in_i,
        output res_ready_i,
        input  op_ready_o,
        input  in_ready_o,
        input  bus_out_o,
        input  dut_rst_n_o,
        input  res_data_o,
        input  res_valid_o
    );
endinterface

// File: rtl/ternary_bus_driver.sv
// Buffers a load/mult payload, bursts it gap-free onto the accelerator pins with an
// optional DUT reset + command preamble, and captures mult results from uo_out.
module ternary_bus_driver #(
    parameter int IN_LEN     = 16,
    parameter int OUT_LEN    = 8,
    parameter int BIT_WIDTH  = 8,
    parameter int RST_CYCLES = 2,
    parameter int RESULT_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ternary_bus_if.master bus_if
);
    localparam int LOAD_BEATS = 2 * IN_LEN * OUT_LEN / 16;
    localparam int VEC_BEATS  = IN_LEN * BIT_WIDTH / 16;
    localparam int DEPTH      = (LOAD_BEATS > VEC_BEATS) ? LOAD_BEATS : VEC_BEATS;
    localparam int MAX_A      = (DEPTH > RST_CYCLES) ? DEPTH : RST_CYCLES;
    localparam int MAX_B      = (RESULT_LAT > OUT_LEN) ? RESULT_LAT : OUT_LEN;
    localparam int MAX_CNT    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W      = $clog2(MAX_CNT + 1);
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit HAS_WAIT   = (RESULT_LAT > 1);

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_BEATS - 1);
    localparam logic [CNT_W-1:0] VEC_LAST  = CNT_W'(VEC_BEATS - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(HAS_WAIT ? RESULT_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] CAPT_LAST = CNT_W'(OUT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DRST,
        S_CMD,
        S_BURST,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_mult_q, is_mult_d;
    logic               armed_q, armed_d;
    logic [15:0]        bus_out_q, bus_out_d;
    logic               dut_rst_n_q, dut_rst_n_d;

    logic [15:0]        buf_mem [DEPTH];
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;
    logic [CNT_W-1:0]   beat_last;

    assign wr_en     = (state_q == S_FILL) && bus_if.in_valid_i;
    assign wr_addr   = cnt_q[ADDR_W-1:0];
    assign rd_addr   = cnt_d[ADDR_W-1:0];
    assign beat_last = is_mult_q ? VEC_LAST : LOAD_LAST;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= bus_if.in_data_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_mult_d = is_mult_q;
        armed_d   = armed_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus_if.op_valid_i) begin
                    is_mult_d = bus_if.op_is_mult_i;
                    cnt_d     = '0;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                if (bus_if.in_valid_i) begin
                    if (cnt_q == beat_last) begin
                        cnt_d = '0;
                        // An armed DUT is already in MULT mode, so the preamble is skipped.
                        state_d = (is_mult_q && armed_q) ? S_BURST : S_DRST;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DRST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CMD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CMD: begin
                if (is_mult_q) begin
                    armed_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = S_BURST;
            end
            S_BURST: begin
                if (cnt_q == beat_last) begin
                    cnt_d = '0;
                    if (is_mult_q) begin
                        state_d = HAS_WAIT ? S_WAIT : S_CAPT;
                    end else begin
                        armed_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPT: begin
                if (cnt_q == CAPT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (bus_if.res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin image is computed from the next state so the registered outputs line up with state_q.
    always_comb begin
        bus_out_d   = '0;
        dut_rst_n_d = (state_d != S_DRST);
        if (state_d == S_CMD) begin
            bus_out_d = {2'b00, 1'b1, is_mult_q, 12'h000};
        end else if (state_d == S_BURST) begin
            bus_out_d = (wr_en && (wr_addr == rd_addr)) ? bus_if.in_data_i : buf_mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_mult_q   <= 1'b0;
            armed_q     <= 1'b0;
            bus_out_q   <= '0;
            dut_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_mult_q   <= is_mult_d;
            armed_q     <= armed_d;
            bus_out_q   <= bus_out_d;
            dut_rst_n_q <= dut_rst_n_d;
        end
    end

    // Result byte k is sampled in the k-th CAPT cycle; it holds until the next capture.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_LEN; gi++) begin : g_res
            logic [BIT_WIDTH-1:0] byte_q;
            always_ff @(posedge clk) begin
                if (rst_n && (state_q == S_CAPT) && (cnt_q == CNT_W'(gi))) begin
                    byte_q <= bus_if.bus_in_i;
                end
            end
            assign bus_if.res_data_o[gi*BIT_WIDTH +: BIT_WIDTH] = byte_q;
        end
    endgenerate

    assign bus_if.op_ready_o  = (state_q == S_IDLE);
    assign bus_if.in_ready_o  = (state_q == S_FILL);
    assign bus_if.res_valid_o = (state_q == S_RESP);
    assign bus_if.bus_out_o   = bus_out_q;
    assign bus_if.dut_rst_n_o = dut_rst_n_q;
endmodule

// File: tb/tb_ternary_bus_driver.sv
// Bench for ternary_bus_driver: random payloads and result bytes checked against a
// cycle schedule derived from the op rules (preamble, burst, latency, capture window).
module tb_ternary_bus_driver;
    localparam int IN_LEN     = 16;
    localparam int OUT_LEN    = 8;
    localparam int BIT_WIDTH  = 8;
    localparam int RST_CYCLES = 2;
    localparam int RESULT_LAT = 2;
    localparam int LOAD_BEATS = 2 * IN_LEN * OUT_LEN / 16;
    localparam int VEC_BEATS  = IN_LEN * BIT_WIDTH / 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ternary_bus_if #(.OUT_LEN(OUT_LEN), .BIT_WIDTH(BIT_WIDTH)) bus ();

    ternary_bus_driver #(
        .IN_LEN    (IN_LEN),
        .OUT_LEN   (OUT_LEN),
        .BIT_WIDTH (BIT_WIDTH),
        .RST_CYCLES(RST_CYCLES),
        .RESULT_LAT(RESULT_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bus)
    );

    int          checks  = 0;
    int          errors  = 0;
    bit          armed_m = 1'b0;
    logic [15:0] beats  [LOAD_BEATS];
    logic [7:0]  rbytes [OUT_LEN];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic randomize_payload();
        for (int b = 0; b < LOAD_BEATS; b++) beats[b] = 16'($urandom);
        for (int k = 0; k < OUT_LEN; k++) rbytes[k] = 8'($urandom);
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        bus.op_valid_i  = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.res_ready_i = 1'b0;
        repeat (n) @(negedge clk);
        check("rst_bus_out", bus.bus_out_o, 0);
        check("rst_dut_rst_n", bus.dut_rst_n_o, 0);
        check("rst_res_valid", bus.res_valid_o, 0);
        check("rst_in_ready", bus.in_ready_o, 0);
        check("rst_op_ready", bus.op_ready_o, 1);
        rst_n   = 1'b1;
        armed_m = 1'b0;
        @(negedge clk);
        check("rel_dut_rst_n", bus.dut_rst_n_o, 1);
        check("rel_op_ready", bus.op_ready_o, 1);
        check("rel_bus_out", bus.bus_out_o, 0);
        $display("reset applied for %0d cycles", n);
    endtask

    // Schedule index 0 is the cycle right after the last payload beat is accepted.
    task automatic run_op(input bit mult, input int abort_idx, input int hold);
        int          n, pre, last, k;
        logic [15:0] eb;
        logic        er;
        logic [63:0] exp_res;
        n    = mult ? VEC_BEATS : LOAD_BEATS;
        pre  = (mult && armed_m) ? 0 : RST_CYCLES + 1;
        last = mult ? pre + n + RESULT_LAT - 1 + OUT_LEN : pre + n;
        exp_res = '0;
        for (int j = 0; j < OUT_LEN; j++) exp_res[8*j +: 8] = rbytes[j];

        check("op_ready_idle", bus.op_ready_o, 1);
        bus.op_valid_i   = 1'b1;
        bus.op_is_mult_i = mult;
        @(negedge clk);
        bus.op_valid_i   = 1'b0;
        bus.op_is_mult_i = 1'($urandom);
        for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid_i = 1'b0;
                bus.in_data_i  = 16'($urandom);
                @(negedge clk);
            end
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = beats[b];
            check("in_ready_fill", bus.in_ready_o, 1);
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;

        for (int idx = 0; idx <= last; idx++) begin
            if (idx == abort_idx) begin
                bus.op_valid_i = 1'b0;
                bus.in_valid_i = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                check("abort_bus_out", bus.bus_out_o, 0);
                check("abort_dut_rst_n", bus.dut_rst_n_o, 0);
                check("abort_res_valid", bus.res_valid_o, 0);
                rst_n   = 1'b1;
                armed_m = 1'b0;
                @(negedge clk);
                check("abort_rel_dut_rst_n", bus.dut_rst_n_o, 1);
                check("abort_rel_op_ready", bus.op_ready_o, 1);
                $display("op %s aborted by reset at schedule cycle %0d", mult ? "mult" : "load", idx);
                return;
            end
            eb = 16'h0000;
            er = 1'b1;
            if (idx < pre - 1) er = 1'b0;
            else if (idx == pre - 1) eb = mult ? 16'h3000 : 16'h2000;
            else if (idx < pre + n) eb = beats[idx - pre];
            k = idx - (pre + n - 1 + RESULT_LAT);
            bus.bus_in_i   = (mult && k >= 0 && k < OUT_LEN) ? rbytes[k] : 8'($urandom);
            bus.in_valid_i = 1'($urandom);
            bus.in_data_i  = 16'($urandom);
            bus.op_valid_i = (idx == last) ? 1'b0 : 1'($urandom);
            check("bus_out", bus.bus_out_o, eb);
            check("dut_rst_n", bus.dut_rst_n_o, er);
            check("in_ready_busy", bus.in_ready_o, 0);
            check("op_ready", bus.op_ready_o, (!mult && idx == last));
            check("res_valid", bus.res_valid_o, (mult && idx == last));
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        bus.op_valid_i = 1'b0;
        armed_m = 1'b1;

        if (mult) begin
            check("res_data", bus.res_data_o, exp_res);
            for (int h = 0; h < hold; h++) begin
                bus.op_valid_i = 1'($urandom);
                check("hold_res_valid", bus.res_valid_o, 1);
                check("hold_res_data", bus.res_data_o, exp_res);
                check("hold_op_ready", bus.op_ready_o, 0);
                @(negedge clk);
            end
            bus.op_valid_i  = 1'b0;
            bus.res_ready_i = 1'b1;
            check("hs_res_valid", bus.res_valid_o, 1);
            @(negedge clk);
            bus.res_ready_i = 1'b0;
            check("done_res_valid", bus.res_valid_o, 0);
            check("done_op_ready", bus.op_ready_o, 1);
            check("done_res_data", bus.res_data_o, exp_res);
        end
        $display("op %s pre=%0d beats=%0d hold=%0d res=%h", mult ? "mult" : "load",
                 pre, n, hold, mult ? exp_res : 64'h0);
    endtask

    initial begin
        bus.op_valid_i   = 1'b0;
        bus.op_is_mult_i = 1'b0;
        bus.in_data_i    = 16'h0000;
        bus.in_valid_i   = 1'b0;
        bus.bus_in_i     = 8'h00;
        bus.res_ready_i  = 1'b0;

        apply_reset(3);

        for (int b = 0; b < LOAD_BEATS; b++) beats[b] = 16'(b + 1);
        run_op(1'b0, -1, 0);

        randomize_payload();
        for (int k = 0; k < OUT_LEN; k++) rbytes[k] = 8'((k + 1) * 17);
        run_op(1'b1, -1, 1);

        apply_reset(3);
        randomize_payload();
        run_op(1'b1, -1, 5);

        for (int t = 0; t < 6; t++) begin
            randomize_payload();
            run_op(1'($urandom_range(0, 1)), -1, $urandom_range(0, 3));
        end

        randomize_payload();
        run_op(1'b0, RST_CYCLES + 1 + 5, 0);
        randomize_payload();
        run_op(1'b1, -1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
